// File: rtl/decryption_pkg.sv
// -----------------------------------------------------------------------------
// decryption_pkg
// Shared definitions for the decryption router slice:
//   state_e          - router FSM states (IDLE / RUN / DRAIN)
//   TERM_SYM_DEFAULT - default end-of-frame symbol
//   clog2_min1()     - ceil(log2(n)), never smaller than 1 (for select widths)
// -----------------------------------------------------------------------------
package decryption_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [7:0] TERM_SYM_DEFAULT = 8'hFA;

  // Width needed to encode n distinct values, with a floor of one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'd1 << i) < 32'(n)) ? (i + 1) : r;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/decryption_sym_fifo.sv
// -----------------------------------------------------------------------------
// decryption_sym_fifo
// Synchronous symbol FIFO with first-word-fall-through read port.
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   flush_i        - discard all stored symbols (wins over push/pop)
//   push_i, din_i  - write request and data; accepted when not full, or when
//                    a pop happens in the same cycle
//   pop_i          - remove head symbol (ignored when empty)
//   dout_o         - current head symbol
//   full_o, empty_o, count_o - occupancy status
// DEPTH must be a power of two (pointers wrap naturally).
// -----------------------------------------------------------------------------
module decryption_sym_fifo
  import decryption_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic [DW-1:0]                  din_i,
  input  logic                           pop_i,
  output logic [DW-1:0]                  dout_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [clog2_min1(DEPTH):0]     count_o
);

  localparam int AW = clog2_min1(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  logic do_push_s;
  logic do_pop_s;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign dout_o    = mem_q[rd_q];
  assign do_pop_s  = pop_i && !empty_o;
  // A full FIFO can still take a symbol when the head leaves in the same cycle.
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push_s) begin
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/decryption_router.sv
// -----------------------------------------------------------------------------
// decryption_router
// Unpacks MST_DWIDTH-bit master words into SYS_DWIDTH-bit symbols (MSB lane
// first), queues them in a symbol FIFO and dispatches them one at a time to the
// decryption channel latched at frame start. A frame ends when TERM_SYM is
// dispatched; the router then drains and returns to IDLE. Results from the
// selected channel are merged onto data_o/valid_o with one cycle of latency.
// Ports:
//   clk_sys, rst           - clock, asynchronous active-high reset
//   data_i, valid_i, busy  - master word input with backpressure
//   sel                    - channel select, sampled only when a frame starts
//   ch_data_o, ch_valid_o, ch_busy_i - per-channel symbol dispatch
//   ch_data_i, ch_valid_i  - per-channel results
//   data_o, valid_o        - merged result
//   drop_cnt               - saturating count of words offered while busy
//                            (only with DECRYPTION_ROUTER_DROPCNT_EN defined)
// -----------------------------------------------------------------------------
module decryption_router
  import decryption_pkg::*;
#(
  parameter int                        MST_DWIDTH = 32,
  parameter int                        SYS_DWIDTH = 8,
  parameter int                        NUM_CH     = 3,
  parameter int                        FIFO_DEPTH = 8,
  parameter logic [SYS_DWIDTH-1:0]     TERM_SYM   = SYS_DWIDTH'(TERM_SYM_DEFAULT)
) (
  input  logic                           clk_sys,
  input  logic                           rst,
  input  logic [MST_DWIDTH-1:0]          data_i,
  input  logic                           valid_i,
  output logic                           busy,
  input  logic [clog2_min1(NUM_CH)-1:0]  sel,
  output logic [NUM_CH*SYS_DWIDTH-1:0]   ch_data_o,
  output logic [NUM_CH-1:0]              ch_valid_o,
  input  logic [NUM_CH-1:0]              ch_busy_i,
  input  logic [NUM_CH*SYS_DWIDTH-1:0]   ch_data_i,
  input  logic [NUM_CH-1:0]              ch_valid_i,
  output logic [SYS_DWIDTH-1:0]          data_o,
  output logic                           valid_o
`ifdef DECRYPTION_ROUTER_DROPCNT_EN
  ,
  output logic [15:0]                    drop_cnt
`endif
);

  localparam int LANES  = MST_DWIDTH / SYS_DWIDTH;
  localparam int SEL_W  = clog2_min1(NUM_CH);
  localparam int CNT_W  = clog2_min1(FIFO_DEPTH) + 1;
  localparam int LCNT_W = clog2_min1(LANES + 1);

  state_e                        state_q;
  logic [SEL_W-1:0]              sel_q;
  logic [MST_DWIDTH-1:0]         word_q;
  logic [LCNT_W-1:0]             lanes_q;
  logic [NUM_CH*SYS_DWIDTH-1:0]  ch_data_q;
  logic [NUM_CH-1:0]             ch_valid_q;
  logic [SYS_DWIDTH-1:0]         data_q;
  logic                          valid_q;

  logic                          busy_sel_s;
  logic                          res_valid_s;
  logic [SYS_DWIDTH-1:0]         res_data_s;
  logic [SYS_DWIDTH-1:0]         lane_sym_s;
  logic [SYS_DWIDTH-1:0]         fifo_head_s;
  logic                          fifo_full_s;
  logic                          fifo_empty_s;
  logic [CNT_W-1:0]              fifo_count_s;
  logic [CNT_W-1:0]              free_s;
  logic                          pop_s;
  logic                          push_s;
  logic                          term_disp_s;
  logic                          lane_term_s;
  logic                          busy_s;
  logic                          accept_s;

  // Select the latched channel's busy and result signals; an out-of-range
  // sel_q reads as never busy and never producing results.
  always_comb begin
    busy_sel_s  = 1'b0;
    res_valid_s = 1'b0;
    res_data_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy_sel_s  = (sel_q == SEL_W'(i)) ? ch_busy_i[i]  : busy_sel_s;
      res_valid_s = (sel_q == SEL_W'(i)) ? ch_valid_i[i] : res_valid_s;
      res_data_s  = (sel_q == SEL_W'(i)) ? ch_data_i[i*SYS_DWIDTH +: SYS_DWIDTH] : res_data_s;
    end
  end

  assign lane_sym_s  = word_q[MST_DWIDTH-1 -: SYS_DWIDTH];
  assign pop_s       = !fifo_empty_s && !busy_sel_s;
  assign term_disp_s = pop_s && (fifo_head_s == TERM_SYM);
  assign push_s      = (lanes_q != '0) && (!fifo_full_s || pop_s);
  assign lane_term_s = push_s && (lane_sym_s == TERM_SYM);
  assign free_s      = CNT_W'(FIFO_DEPTH) - fifo_count_s;
  // Only take a new word when all of its lanes are guaranteed a FIFO slot.
  assign busy_s      = (lanes_q != '0) || (state_q == ST_DRAIN) ||
                       (free_s < CNT_W'(LANES));
  assign accept_s    = valid_i && !busy_s;

  decryption_sym_fifo #(
    .DW    (SYS_DWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (rst),
    .flush_i (term_disp_s),
    .push_i  (push_s),
    .din_i   (lane_sym_s),
    .pop_i   (pop_s),
    .dout_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Unpack register: load on accept, shift out one lane per push. Lanes after
  // a terminator, and anything still unpacking when the terminator is
  // dispatched, belong past the end of the frame and are dropped.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      lanes_q <= '0;
    end else if (term_disp_s) begin
      lanes_q <= '0;
    end else if (accept_s) begin
      word_q  <= data_i;
      lanes_q <= LCNT_W'(LANES);
    end else if (push_s) begin
      word_q  <= word_q << SYS_DWIDTH;
      lanes_q <= lane_term_s ? '0 : (lanes_q - LCNT_W'(1));
    end
  end

  // Frame FSM with registered dispatch and result outputs.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      ch_data_q  <= '0;
      ch_valid_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      ch_valid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (pop_s && (sel_q == SEL_W'(i))) begin
          ch_valid_q[i]                              <= 1'b1;
          ch_data_q[i*SYS_DWIDTH +: SYS_DWIDTH]      <= fifo_head_s;
        end
      end
      valid_q <= res_valid_s;
      if (res_valid_s) begin
        data_q <= res_data_s;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q <= ST_RUN;
            sel_q   <= sel;
          end
        end
        ST_RUN: begin
          if (term_disp_s) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!busy_sel_s && fifo_empty_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DECRYPTION_ROUTER_DROPCNT_EN
  logic [15:0] drop_q;

  // Saturating count of words presented while backpressured.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      drop_q <= 16'h0000;
    end else if (valid_i && busy_s && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

  assign busy       = busy_s;
  assign ch_data_o  = ch_data_q;
  assign ch_valid_o = ch_valid_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_decryption_router.sv
module tb_decryption_router;
  import decryption_pkg::*;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic        valid_i;
  logic        busy;
  logic [1:0]  sel;
  logic [23:0] ch_data_o;
  logic [2:0]  ch_valid_o;
  logic [2:0]  ch_busy_i;
  logic [23:0] ch_data_i;
  logic [2:0]  ch_valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
`ifdef DECRYPTION_ROUTER_DROPCNT_EN
  logic [15:0] drop_cnt;
`endif

  decryption_router dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .busy       (busy),
    .sel        (sel),
    .ch_data_o  (ch_data_o),
    .ch_valid_o (ch_valid_o),
    .ch_busy_i  (ch_busy_i),
    .ch_data_i  (ch_data_i),
    .ch_valid_i (ch_valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o)
`ifdef DECRYPTION_ROUTER_DROPCNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int         ch;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] out_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         pulse_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic expect_sym(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every dispatch pulse and merged result against the queues.
  always @(negedge clk_sys) begin
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        if (ch_valid_o[c]) begin
          pulse_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse_ch", 32'(c), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_channel", 32'(c), 32'(e.ch));
            chk("pulse_data", 32'(ch_data_o[c*8 +: 8]), 32'(e.d));
          end
        end
      end
      if (valid_o) begin
        if (out_q.size() == 0) begin
          chk("unexpected_valid_o", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          logic [7:0] d;
          d = out_q.pop_front();
          chk("merged_data", 32'(data_o), 32'(d));
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk("send_ready", 32'(busy), 32'd0);
    data_i  = w;
    valid_i = 1'b1;
    @(posedge clk_sys); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && dut.state_q == ST_IDLE) && n < 300) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk(nm, {31'd0, (exp_q.size() == 0 && dut.state_q == ST_IDLE)}, 32'd1);
  endtask

  initial begin
    int p0;
    rst        = 1'b1;
    data_i     = 32'h0;
    valid_i    = 1'b0;
    sel        = 2'd0;
    ch_busy_i  = 3'b000;
    ch_data_i  = 24'h0;
    ch_valid_i = 3'b000;
    repeat (3) @(posedge clk_sys);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ch_valid", 32'(ch_valid_o), 32'd0);
    chk("rst_ch_data", 32'(ch_data_o), 32'd0);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Basic frame on channel 0
    sel = 2'd0;
    expect_sym(0, 8'h41); expect_sym(0, 8'h42); expect_sym(0, 8'h43);
    expect_sym(0, 8'h44); expect_sym(0, 8'hFA);
    send_word(32'h41424344);
    send_word(32'hFA000000);
    wait_idle("basic_frame_done");

    // Channel 1 held busy: FIFO fills, nothing dispatched, then drains in order
    sel       = 2'd1;
    ch_busy_i = 3'b010;
    p0        = pulse_cnt;
    expect_sym(1, 8'h41); expect_sym(1, 8'h42); expect_sym(1, 8'h43); expect_sym(1, 8'h44);
    expect_sym(1, 8'h45); expect_sym(1, 8'h46); expect_sym(1, 8'h47); expect_sym(1, 8'h48);
    expect_sym(1, 8'hFA);
    send_word(32'h41424344);
    send_word(32'h45464748);
    repeat (12) @(posedge clk_sys);
    #1;
    chk("full_count", 32'(dut.u_fifo.count_o), 32'd8);
    chk("full_busy", 32'(busy), 32'd1);
    chk("held_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    sel       = 2'd0;
    ch_busy_i = 3'b000;
    send_word(32'hFA000000);
    wait_idle("held_frame_done");

    // Terminator mid-word discards remaining lanes
    sel = 2'd0;
    expect_sym(0, 8'h41); expect_sym(0, 8'hFA);
    send_word(32'h41FA4243);
    wait_idle("term_mid_word_done");
    repeat (3) @(posedge clk_sys);
    #1;
    chk("term_mid_word_lane0", 32'(ch_data_o[7:0]), 32'hFA);

    // Result merge: other channel ignored, selected channel one cycle later
    ch_data_i  = 24'h007700;
    ch_valid_i = 3'b010;
    @(posedge clk_sys); #1;
    ch_valid_i = 3'b000;
    chk("other_ch_ignored", 32'(valid_o), 32'd0);
    ch_data_i  = 24'h000055;
    ch_valid_i = 3'b001;
    out_q.push_back(8'h55);
    @(posedge clk_sys); #1;
    ch_valid_i = 3'b000;
    chk("merge_valid", 32'(valid_o), 32'd1);
    chk("merge_data", 32'(data_o), 32'h55);
    @(posedge clk_sys); #1;
    chk("merge_valid_drop", 32'(valid_o), 32'd0);

    // Drops while busy, then reset mid-frame
    sel       = 2'd0;
    ch_busy_i = 3'b001;
    send_word(32'h11223344);
    send_word(32'h55667788);
    repeat (6) @(posedge clk_sys);
    #1;
    chk("drop_pre_busy", 32'(busy), 32'd1);
    data_i  = 32'hDEADBEEF;
    valid_i = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    valid_i = 1'b0;
    chk("drop_no_change", 32'(dut.u_fifo.count_o), 32'd8);
`ifdef DECRYPTION_ROUTER_DROPCNT_EN
    chk("drop_cnt_3", 32'(drop_cnt), 32'd3);
`endif
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ch_data", 32'(ch_data_o), 32'd0);
    chk("midrst_data_o", 32'(data_o), 32'd0);
    @(posedge clk_sys); #1;
    chk("midrst_ch_valid", 32'(ch_valid_o), 32'd0);
    chk("midrst_valid_o", 32'(valid_o), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("midrst_fifo", 32'(dut.u_fifo.count_o), 32'd0);
`ifdef DECRYPTION_ROUTER_DROPCNT_EN
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    exp_q.delete();
    out_q.delete();
    ch_busy_i = 3'b000;
    rst       = 1'b0;
    @(posedge clk_sys); #1;

    // Select change mid-frame is ignored; next frame uses the new channel
    sel = 2'd0;
    expect_sym(0, 8'h61); expect_sym(0, 8'h62); expect_sym(0, 8'h63);
    expect_sym(0, 8'h64); expect_sym(0, 8'h65); expect_sym(0, 8'hFA);
    send_word(32'h61626364);
    sel = 2'd2;
    send_word(32'h65FA0000);
    wait_idle("sel_mid_frame_done");
    expect_sym(2, 8'h71); expect_sym(2, 8'hFA);
    send_word(32'h71FA0000);
    wait_idle("sel_next_frame_done");
    repeat (2) @(posedge clk_sys);
    #1;
    chk("lane0_hold", 32'(ch_data_o[7:0]), 32'hFA);
    chk("lane2_last", 32'(ch_data_o[23:16]), 32'hFA);

    repeat (4) @(posedge clk_sys);
    #1;
    chk("final_queue_empty", 32'(exp_q.size() + out_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decryption_router.md
DECRYPTION_ROUTER -- requirements
Module: decryption_router

Interface
REQ-001 SHALL have parameter MST_DWIDTH, default 32, master input word width; must be an integer multiple of SYS_DWIDTH.
REQ-002 SHALL have parameter SYS_DWIDTH, default 8, symbol width.
REQ-003 SHALL have parameter NUM_CH, default 3, number of decryption channels; range 1..8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, symbol FIFO depth; power of two, minimum 2.
REQ-005 SHALL have parameter TERM_SYM, default 8'hFA, end-of-frame symbol.
REQ-006 SHALL have port clk_sys  in  1  sole clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports data_i  in  MST_DWIDTH  packed input word; valid_i  in  1  word qualifier; busy  out  1  input backpressure.
REQ-009 SHALL have port sel  in  SEL_W  channel select, where SEL_W = clog2(NUM_CH), minimum 1.
REQ-010 SHALL have ports ch_data_o  out  NUM_CH*SYS_DWIDTH  per-channel symbol; ch_valid_o  out  NUM_CH  per-channel strobe; ch_busy_i  in  NUM_CH  per-channel busy.
REQ-011 SHALL have ports ch_data_i  in  NUM_CH*SYS_DWIDTH  channel results; ch_valid_i  in  NUM_CH  result strobes.
REQ-012 SHALL have ports data_o  out  SYS_DWIDTH  merged result; valid_o  out  1  result strobe.

Function
REQ-013 SHALL accept a word when valid_i=1 and busy=0, loading it into the unpack register.
REQ-014 SHALL treat valid_i=1 while busy=1 as a dropped word; no state change.
REQ-015 SHALL unpack LANES=MST_DWIDTH/SYS_DWIDTH symbols, MSB lane first, one per cycle, pushing into the FIFO only while it is not full; the first push is the cycle after acceptance.
REQ-016 SHALL assert busy while unpacked lanes remain, while in DRAIN, and while FIFO free slots are fewer than LANES.
REQ-017 SHALL run FSM IDLE -> RUN on first accepted word; RUN -> DRAIN when TERM_SYM is dispatched; DRAIN -> IDLE when ch_busy_i[sel_q]=0 and the FIFO is empty.
REQ-018 SHALL latch sel into sel_q on the IDLE->RUN transition; sel changes outside IDLE SHALL be ignored.
REQ-019 SHALL pop the FIFO head when non-empty and ch_busy_i[sel_q]=0, driving it on ch_data_o lane sel_q with a one-cycle ch_valid_o[sel_q] pulse in the pop cycle (registered, one cycle after the head becomes visible).
REQ-020 SHALL discard remaining lanes of the word containing TERM_SYM and flush symbols already in the FIFO after TERM_SYM.
REQ-021 SHALL, when sel_q >= NUM_CH, pop and discard symbols with no ch_valid_o pulse, still honouring TERM_SYM.
REQ-022 SHALL allow simultaneous FIFO push and pop, including when full; occupancy is then unchanged.
REQ-023 SHALL register data_o/valid_o from ch_data_i/ch_valid_i[sel_q] with one-cycle latency and ignore strobes from other channels.
REQ-024 SHALL hold ch_data_o lanes at their last value when not strobing.

Reset
REQ-025 SHALL on rst=1, immediately and mid-operation, clear: FSM to IDLE, FIFO empty, unpack register empty, sel_q=0, busy=0, ch_valid_o=0, ch_data_o=0, valid_o=0, data_o=0.

Configuration
REQ-026 SHALL, with DECRYPTION_ROUTER_DROPCNT_EN defined, add output drop_cnt  out  16, counting REQ-014 drops, saturating at 16'hFFFF, cleared by reset.
REQ-027 SHALL, without DECRYPTION_ROUTER_DROPCNT_EN, omit drop_cnt and its counter entirely.

Structure
REQ-028 SHALL take the FSM state enum, TERM_SYM default and the clog2 helper from shared package decryption_pkg.
REQ-029 SHALL implement the symbol FIFO as sub-module decryption_sym_fifo (push/pop/full/empty/count).

Verification
REQ-030 SHALL cover sel=0, word 32'h41424344 then 32'hFA000000 -> ch_valid_o[0] pulses with 41,42,43,44,FA in order; FSM returns to IDLE.
REQ-031 SHALL cover ch_busy_i[1] held high 20 cycles with sel=1 -> FIFO fills to 8, busy=1, no pulses; on release 8 symbols emitted in order with no loss.
REQ-032 SHALL cover sel changed 0->2 mid-frame -> symbols still go to channel 0; the next frame goes to channel 2.
REQ-033 SHALL cover word 32'h41FA4243 -> only 41 and FA dispatched; 42 and 43 discarded.
REQ-034 SHALL cover valid_i held high during busy for 3 cycles with the macro defined -> drop_cnt=3; rst mid-frame -> all outputs 0 next edge, drop_cnt=0.
REQ-035 SHALL cover ch_valid_i[1]=1 with sel_q=0 -> valid_o stays 0; ch_valid_i[0]=1, data 8'h55 -> valid_o=1, data_o=8'h55 one cycle later.
